// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, instruction field positions,
// immediate formats and small decode helpers used by the decode/issue slice.
package rv32_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    // Immediate format implied by the opcode; OP and unknown opcodes carry none.
    function automatic imm_fmt_e fmt_of(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC:             return IMM_U;
            OPC_JAL:                        return IMM_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: return IMM_I;
            OPC_STORE:                      return IMM_S;
            OPC_BRANCH:                     return IMM_B;
            default:                        return IMM_NONE;
        endcase
    endfunction

    // rs1 is read by I/S/B formats and by register-register OP.
    function automatic logic uses_rs1(input imm_fmt_e fmt, input logic [6:0] opc);
        return (fmt == IMM_I) || (fmt == IMM_S) || (fmt == IMM_B) || (opc == OPC_OP);
    endfunction

    // rs2 is read by S/B formats and by register-register OP.
    function automatic logic uses_rs2(input imm_fmt_e fmt, input logic [6:0] opc);
        return (fmt == IMM_S) || (fmt == IMM_B) || (opc == OPC_OP);
    endfunction

    // Instruction produces a register result that is not discarded into x0.
    function automatic logic rd_writes(input logic [31:0] instr);
        logic [6:0] opc;
        opc = instr[OPC_MSB:OPC_LSB];
        return (opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
                            OPC_LOAD, OPC_OP_IMM, OPC_OP})
               && (instr[RD_MSB:RD_LSB] != 5'd0);
    endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// Combinational immediate generator: classifies the instruction format and
// produces the RV32I immediate sign-extended to XLEN (zero for no format).
module rv32_imm_gen
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    // Format follows directly from the opcode.
    always_comb begin
        fmt = fmt_of(instr[OPC_MSB:OPC_LSB]);
    end

    // Reassemble the scattered immediate bits for each format.
    always_comb begin
        imm32 = 32'd0;
        case (fmt)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7],
                              instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'd0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                              instr[20], instr[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
        imm = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/rv32_decode_issue.sv
// Decode/issue stage: drives register-file read selects, holds one
// instruction in D while its operands return, blocks RAW/WAW hazards with a
// pending-write scoreboard and hands operand bundles to execute.
module rv32_decode_issue
    import rv32_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic [4:0]      rf_sel_s1,
    output logic [4:0]      rf_sel_s2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [31:0]     ex_instr,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic            ex_rd_wr
);

    logic            d_valid_q, d_valid_d;
    logic [XLEN-1:0] d_pc_q, d_pc_d;
    logic [31:0]     d_instr_q, d_instr_d;
    logic            stale1_q, stale1_d, stale2_q, stale2_d, staled_q, staled_d;
    logic [NREG-1:0] pending_q, pending_d;

    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] ex_pc_q, ex_pc_d, ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
    logic [XLEN-1:0] ex_imm_q, ex_imm_d;
    logic [31:0]     ex_instr_q, ex_instr_d;
    logic [4:0]      ex_rd_q, ex_rd_d;
    logic            ex_rd_wr_q, ex_rd_wr_d;

    logic            d_issue, d_rd_wr, capture;
    logic [4:0]      d_rd, cand_rd;
    logic [31:0]     sel_instr;
    imm_fmt_e        d_fmt, sel_fmt;
    logic [XLEN-1:0] d_imm;

    rv32_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (d_instr_q),
        .fmt   (d_fmt),
        .imm   (d_imm)
    );

    // A register is stale if an older write is outstanding and not landing
    // this cycle, or the instruction issuing right now is about to claim it.
    function automatic logic is_stale(input logic [4:0] r, input logic [NREG-1:0] pend,
                                      input logic wb_v, input logic [4:0] wb_r,
                                      input logic iss_wr, input logic [4:0] iss_rd);
        return (r != 5'd0) && ((pend[r] && !(wb_v && (wb_r == r))) ||
                               (iss_wr && (iss_rd == r)));
    endfunction

    // Issue/accept handshakes, RF select mux and stale-flag evaluation.
    always_comb begin
        d_rd      = d_instr_q[RD_MSB:RD_LSB];
        d_rd_wr   = rd_writes(d_instr_q);
        d_issue   = d_valid_q && !stale1_q && !stale2_q && !staled_q &&
                    (!ex_valid_q || ex_ready) && !flush;
        if_ready  = !d_valid_q || d_issue;
        capture   = if_valid && if_ready && !flush;
        // A stalled instruction keeps re-reading so it sees the bypassed value.
        sel_instr = (d_valid_q && !d_issue) ? d_instr_q : if_instr;
        sel_fmt   = fmt_of(sel_instr[OPC_MSB:OPC_LSB]);
        rf_sel_s1 = uses_rs1(sel_fmt, sel_instr[OPC_MSB:OPC_LSB]) ?
                    sel_instr[RS1_MSB:RS1_LSB] : 5'd0;
        rf_sel_s2 = uses_rs2(sel_fmt, sel_instr[OPC_MSB:OPC_LSB]) ?
                    sel_instr[RS2_MSB:RS2_LSB] : 5'd0;
        cand_rd   = rd_writes(sel_instr) ? sel_instr[RD_MSB:RD_LSB] : 5'd0;
        stale1_d  = is_stale(rf_sel_s1, pending_q, wb_valid, wb_rd, d_issue && d_rd_wr, d_rd);
        stale2_d  = is_stale(rf_sel_s2, pending_q, wb_valid, wb_rd, d_issue && d_rd_wr, d_rd);
        staled_d  = is_stale(cand_rd,   pending_q, wb_valid, wb_rd, d_issue && d_rd_wr, d_rd);
    end

    // D register next state: flush kills, capture refills, issue drains.
    always_comb begin
        d_valid_d = d_valid_q;
        d_pc_d    = d_pc_q;
        d_instr_d = d_instr_q;
        if (flush) begin
            d_valid_d = 1'b0;
        end else if (capture) begin
            d_valid_d = 1'b1;
            d_pc_d    = if_pc;
            d_instr_d = if_instr;
        end else if (d_issue) begin
            d_valid_d = 1'b0;
        end
    end

    // Output bundle register: load on issue, drop on handoff or flush.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_pc_d    = ex_pc_q;
        ex_instr_d = ex_instr_q;
        ex_rs1_d   = ex_rs1_q;
        ex_rs2_d   = ex_rs2_q;
        ex_imm_d   = ex_imm_q;
        ex_rd_d    = ex_rd_q;
        ex_rd_wr_d = ex_rd_wr_q;
        if (d_issue) begin
            ex_valid_d = 1'b1;
            ex_pc_d    = d_pc_q;
            ex_instr_d = d_instr_q;
            ex_rs1_d   = uses_rs1(d_fmt, d_instr_q[OPC_MSB:OPC_LSB]) ? rf_rdata1 : '0;
            ex_rs2_d   = uses_rs2(d_fmt, d_instr_q[OPC_MSB:OPC_LSB]) ? rf_rdata2 : '0;
            ex_imm_d   = d_imm;
            ex_rd_d    = d_rd;
            ex_rd_wr_d = d_rd_wr;
        end else if (ex_valid_q && (ex_ready || flush)) begin
            ex_valid_d = 1'b0;
        end
    end

    // Scoreboard: writebacks and flushed bundles clear, issue sets (set wins).
    always_comb begin
        pending_d = pending_q;
        if (wb_valid) begin
            pending_d[wb_rd] = 1'b0;
        end
        if (flush && ex_valid_q && !ex_ready && ex_rd_wr_q) begin
            pending_d[ex_rd_q] = 1'b0;
        end
        if (d_issue && d_rd_wr) begin
            pending_d[d_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid_q  <= 1'b0;
            d_pc_q     <= '0;
            d_instr_q  <= '0;
            stale1_q   <= 1'b0;
            stale2_q   <= 1'b0;
            staled_q   <= 1'b0;
            pending_q  <= '0;
            ex_valid_q <= 1'b0;
            ex_pc_q    <= '0;
            ex_instr_q <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_imm_q   <= '0;
            ex_rd_q    <= '0;
            ex_rd_wr_q <= 1'b0;
        end else begin
            d_valid_q  <= d_valid_d;
            d_pc_q     <= d_pc_d;
            d_instr_q  <= d_instr_d;
            stale1_q   <= stale1_d;
            stale2_q   <= stale2_d;
            staled_q   <= staled_d;
            pending_q  <= pending_d;
            ex_valid_q <= ex_valid_d;
            ex_pc_q    <= ex_pc_d;
            ex_instr_q <= ex_instr_d;
            ex_rs1_q   <= ex_rs1_d;
            ex_rs2_q   <= ex_rs2_d;
            ex_imm_q   <= ex_imm_d;
            ex_rd_q    <= ex_rd_d;
            ex_rd_wr_q <= ex_rd_wr_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_pc      = ex_pc_q;
    assign ex_instr   = ex_instr_q;
    assign ex_rs1_val = ex_rs1_q;
    assign ex_rs2_val = ex_rs2_q;
    assign ex_imm     = ex_imm_q;
    assign ex_rd      = ex_rd_q;
    assign ex_rd_wr   = ex_rd_wr_q;

endmodule

// File: tb/tb_rv32_decode_issue.sv
// Directed bench for rv32_decode_issue with a small register-file model
// (registered read, same-cycle writeback bypass) feeding the read ports.
module tb_rv32_decode_issue;

    logic        clk;
    logic        rst_n;
    logic        if_valid, if_ready;
    logic [31:0] if_instr, if_pc;
    logic [4:0]  rf_sel_s1, rf_sel_s2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_rd_wr;

    int errors = 0;
    int checks = 0;

    logic [31:0] regs [32];

    rv32_decode_issue #(.XLEN(32), .NREG(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .rf_sel_s1  (rf_sel_s1),
        .rf_sel_s2  (rf_sel_s2),
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_pc      (ex_pc),
        .ex_instr   (ex_instr),
        .ex_rs1_val (ex_rs1_val),
        .ex_rs2_val (ex_rs2_val),
        .ex_imm     (ex_imm),
        .ex_rd      (ex_rd),
        .ex_rd_wr   (ex_rd_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: x0 reads zero, writeback bypasses into same-cycle reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
            rf_rdata1 <= 32'd0;
            rf_rdata2 <= 32'd0;
        end else begin
            if (wb_valid && wb_rd != 5'd0) regs[wb_rd] <= wb_data;
            rf_rdata1 <= (rf_sel_s1 == 5'd0) ? 32'd0 :
                         (wb_valid && wb_rd == rf_sel_s1) ? wb_data : regs[rf_sel_s1];
            rf_rdata2 <= (rf_sel_s2 == 5'd0) ? 32'd0 :
                         (wb_valid && wb_rd == rf_sel_s2) ? wb_data : regs[rf_sel_s2];
        end
    end

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b0110111};
    endfunction
    function automatic logic [31:0] enc_beq(input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
    endtask

    task automatic wb_pulse(input logic [4:0] rd, input logic [31:0] data);
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_data  = data;
        tick();
        wb_valid = 1'b0;
        $display("writeback x%0d <= 0x%08h", rd, data);
    endtask

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0;
        wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; flush = 1'b0; ex_ready = 1'b1;
        tick(); tick();
        chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset_ex_imm", ex_imm, 32'd0);
        chk("reset_pending", dut.pending_q, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("reset_if_ready", {31'd0, if_ready}, 32'd1);

        // Back-to-back independent ADDIs.
        offer(enc_addi(5'd1, 5'd0, 12'd5), 32'h100);
        #1 chk("addi1_sel_s1", {27'd0, rf_sel_s1}, 32'd0);
        tick();
        offer(enc_addi(5'd2, 5'd0, 12'd7), 32'h104);
        #1 chk("addi2_if_ready", {31'd0, if_ready}, 32'd1);
        chk("addi2_sel_s1", {27'd0, rf_sel_s1}, 32'd0);
        chk("addi_lat_not_yet", {31'd0, ex_valid}, 32'd0);
        tick();
        if_valid = 1'b0;
        chk("addi1_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("addi1_ex_imm", ex_imm, 32'd5);
        chk("addi1_ex_rd", {27'd0, ex_rd}, 32'd1);
        chk("addi1_ex_pc", ex_pc, 32'h100);
        $display("issue pc=0x%08h rd=%0d imm=0x%08h", ex_pc, ex_rd, ex_imm);
        tick();
        chk("addi2_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("addi2_ex_imm", ex_imm, 32'd7);
        chk("addi2_ex_rd", {27'd0, ex_rd}, 32'd2);
        $display("issue pc=0x%08h rd=%0d imm=0x%08h", ex_pc, ex_rd, ex_imm);
        tick();
        chk("addi_drain", {31'd0, ex_valid}, 32'd0);
        chk("addi_pending", dut.pending_q, 32'h0000_0006);
        wb_pulse(5'd1, 32'h11);
        wb_pulse(5'd2, 32'h22);
        chk("addi_pending_clr", dut.pending_q, 32'd0);

        // RAW stall on x3 released by a writeback of 0x2A.
        offer(enc_addi(5'd3, 5'd0, 12'd1), 32'h200);
        tick();
        offer(enc_add(5'd4, 5'd3, 5'd3), 32'h204);
        #1 chk("raw_sel_s1", {27'd0, rf_sel_s1}, 32'd3);
        tick();
        offer(enc_addi(5'd6, 5'd0, 12'd9), 32'h208);
        #1 chk("raw_if_ready_held", {31'd0, if_ready}, 32'd0);
        chk("raw_addi3_out", {27'd0, ex_rd}, 32'd3);
        chk("raw_reread_sel", {27'd0, rf_sel_s2}, 32'd3);
        tick();
        chk("raw_bubble", {31'd0, ex_valid}, 32'd0);
        chk("raw_still_held", {31'd0, if_ready}, 32'd0);
        wb_pulse(5'd3, 32'h2A);
        #1 chk("raw_release_ready", {31'd0, if_ready}, 32'd1);
        tick();
        if_valid = 1'b0;
        chk("raw_add_valid", {31'd0, ex_valid}, 32'd1);
        chk("raw_add_rd", {27'd0, ex_rd}, 32'd4);
        chk("raw_add_rs1", ex_rs1_val, 32'h2A);
        chk("raw_add_rs2", ex_rs2_val, 32'h2A);
        chk("raw_pending3_clr", {31'd0, dut.pending_q[3]}, 32'd0);
        $display("issue pc=0x%08h rd=%0d rs1=0x%08h rs2=0x%08h", ex_pc, ex_rd, ex_rs1_val, ex_rs2_val);
        tick();
        chk("raw_next_rd", {27'd0, ex_rd}, 32'd6);
        chk("raw_next_imm", ex_imm, 32'd9);
        tick();
        wb_pulse(5'd4, 32'h44);
        wb_pulse(5'd6, 32'h66);

        // Writeback to x5 in the same cycle LW x5 issues: the set wins.
        offer(enc_lw(5'd5, 5'd0, 12'd0), 32'h300);
        tick();
        offer(enc_addi(5'd8, 5'd5, 12'd1), 32'h304);
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h55;
        tick();
        wb_valid = 1'b0; if_valid = 1'b0;
        chk("setclr_pending5", {31'd0, dut.pending_q[5]}, 32'd1);
        chk("setclr_lw_rd", {27'd0, ex_rd}, 32'd5);
        #1 chk("setclr_dep_stall", {31'd0, if_ready}, 32'd0);
        tick(); tick();
        chk("setclr_no_issue", {31'd0, ex_valid}, 32'd0);
        chk("setclr_still_stall", {31'd0, if_ready}, 32'd0);
        wb_pulse(5'd5, 32'h77);
        #1 chk("setclr_release", {31'd0, if_ready}, 32'd1);
        tick();
        chk("setclr_dep_rd", {27'd0, ex_rd}, 32'd8);
        chk("setclr_dep_rs1", ex_rs1_val, 32'h77);
        $display("issue pc=0x%08h rd=%0d rs1=0x%08h", ex_pc, ex_rd, ex_rs1_val);
        tick();
        wb_pulse(5'd8, 32'h88);

        // Backpressure: three instructions offered while execute is stalled.
        ex_ready = 1'b0;
        offer(enc_addi(5'd9, 5'd0, 12'd1), 32'h400);
        tick();
        offer(enc_addi(5'd10, 5'd0, 12'd2), 32'h404);
        tick();
        offer(enc_addi(5'd11, 5'd0, 12'd3), 32'h408);
        #1 chk("bp_full_ready", {31'd0, if_ready}, 32'd0);
        chk("bp_first_rd", {27'd0, ex_rd}, 32'd9);
        tick(); tick(); tick();
        chk("bp_hold_valid", {31'd0, ex_valid}, 32'd1);
        chk("bp_hold_pc", ex_pc, 32'h400);
        chk("bp_hold_imm", ex_imm, 32'd1);
        ex_ready = 1'b1;
        #1 chk("bp_resume_ready", {31'd0, if_ready}, 32'd1);
        tick();
        if_valid = 1'b0;
        chk("bp_second_pc", ex_pc, 32'h404);
        chk("bp_second_rd", {27'd0, ex_rd}, 32'd10);
        tick();
        chk("bp_third_pc", ex_pc, 32'h408);
        chk("bp_third_rd", {27'd0, ex_rd}, 32'd11);
        tick();
        chk("bp_drained", {31'd0, ex_valid}, 32'd0);
        wb_pulse(5'd9, 32'h9);
        wb_pulse(5'd10, 32'hA);
        wb_pulse(5'd11, 32'hB);

        // Flush an unaccepted LUI x7 with another instruction sitting in D.
        ex_ready = 1'b0;
        offer(enc_lui(5'd7, 20'h12345), 32'h500);
        tick();
        offer(enc_addi(5'd12, 5'd0, 12'd4), 32'h504);
        tick();
        if_valid = 1'b0;
        chk("flush_lui_imm", ex_imm, 32'h1234_5000);
        chk("flush_pending7_set", {31'd0, dut.pending_q[7]}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_pending7_clr", {31'd0, dut.pending_q[7]}, 32'd0);
        chk("flush_d_empty", {31'd0, dut.d_valid_q}, 32'd0);
        chk("flush_pending_all", dut.pending_q, 32'd0);
        ex_ready = 1'b1;
        offer(enc_addi(5'd13, 5'd0, 12'd6), 32'h600);
        #1 chk("flush_next_ready", {31'd0, if_ready}, 32'd1);
        tick();
        if_valid = 1'b0;
        tick();
        chk("flush_next_pc", ex_pc, 32'h600);
        chk("flush_next_rd", {27'd0, ex_rd}, 32'd13);
        tick();
        wb_pulse(5'd13, 32'hD);

        // Immediate formats and an unknown opcode.
        offer(enc_beq(5'd0, 5'd0, 13'h1FFC), 32'h700);
        tick();
        offer(enc_jal(5'd1, 21'h000800), 32'h704);
        tick();
        offer(32'hFFFF_FFFF, 32'h708);
        chk("beq_imm", ex_imm, 32'hFFFF_FFFC);
        chk("beq_rd_wr", {31'd0, ex_rd_wr}, 32'd0);
        tick();
        if_valid = 1'b0;
        chk("jal_imm", ex_imm, 32'h0000_0800);
        chk("jal_rd_wr", {31'd0, ex_rd_wr}, 32'd1);
        tick();
        chk("unk_valid", {31'd0, ex_valid}, 32'd1);
        chk("unk_instr", ex_instr, 32'hFFFF_FFFF);
        chk("unk_imm", ex_imm, 32'd0);
        chk("unk_rd_wr", {31'd0, ex_rd_wr}, 32'd0);
        tick();
        wb_pulse(5'd1, 32'h1);

        // Asynchronous reset in the middle of a stall.
        ex_ready = 1'b0;
        offer(enc_addi(5'd14, 5'd0, 12'd1), 32'h800);
        tick();
        offer(enc_addi(5'd15, 5'd14, 12'd1), 32'h804);
        tick();
        if_valid = 1'b0;
        chk("arst_pre_pending", {31'd0, dut.pending_q[14]}, 32'd1);
        chk("arst_pre_valid", {31'd0, ex_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_pending", dut.pending_q, 32'd0);
        chk("arst_d_valid", {31'd0, dut.d_valid_q}, 32'd0);
        chk("arst_ex_pc", ex_pc, 32'd0);
        chk("arst_if_ready", {31'd0, if_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        ex_ready = 1'b1;
        tick();
        chk("post_rst_idle", {31'd0, ex_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
